// File: rtl/param_multicycle_proc.sv
// Multi-cycle processor: fetches from a synchronous ROM and executes mv/mvi/add/sub
// on NREG registers of DATA_W bits, with a combinational debug read port.
module param_multicycle_proc #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREG   = 8,
  parameter int unsigned ADDR_W = 5,
  localparam int unsigned RS    = $clog2(NREG)
) (
  input  logic              M_clock,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] DIN,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] bus,
  output logic              done,
  input  logic [RS-1:0]     dbg_sel,
  output logic [DATA_W-1:0] dbg_q
);

  localparam int unsigned IR_W = 2 + 2 * RS;

  localparam logic [1:0] OP_MV  = 2'b00;
  localparam logic [1:0] OP_MVI = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EXEC,
    S_IMM,
    S_ALU,
    S_WB
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [IR_W-1:0]     ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   g_q, g_d;
  logic [DATA_W-1:0]   bus_q, bus_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   r_q [NREG];

  logic                wr_en;
  logic [DATA_W-1:0]   wr_data;
  logic [1:0]          op;
  logic [RS-1:0]       x_idx, y_idx;
  logic [DATA_W-1:0]   rx, ry;

  assign op    = ir_q[1:0];
  assign x_idx = ir_q[2+RS-1:2];
  assign y_idx = ir_q[2+2*RS-1:2+RS];
  assign rx    = r_q[x_idx];
  assign ry    = r_q[y_idx];

  // State, program counter and datapath registers
  always_ff @(posedge M_clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      bus_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
      bus_q   <= bus_d;
      done_q  <= done_d;
    end
  end

  // Register file
  always_ff @(posedge M_clock) begin
    if (!resetn) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_q[i] <= '0;
      end
    end else if (wr_en) begin
      r_q[x_idx] <= wr_data;
    end
  end

  // done is registered, so it is raised one state ahead of the write step
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    g_d     = g_q;
    bus_d   = bus_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        ir_d    = DIN[IR_W-1:0];
        pc_d    = pc_q + ADDR_W'(1);
        done_d  = (DIN[1:0] == OP_MV);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_MV: begin
            wr_en   = 1'b1;
            wr_data = ry;
            bus_d   = ry;
            state_d = run ? S_FETCH : S_IDLE;
          end
          OP_MVI: begin
            done_d  = 1'b1;
            state_d = S_IMM;
          end
          default: begin
            a_d     = rx;
            state_d = S_ALU;
          end
        endcase
      end
      S_IMM: begin
        wr_en   = 1'b1;
        wr_data = DIN;
        bus_d   = DIN;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_ALU: begin
        g_d     = (op == OP_SUB) ? (a_q - ry) : (a_q + ry);
        done_d  = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        wr_en   = 1'b1;
        wr_data = g_q;
        bus_d   = g_q;
        state_d = run ? S_FETCH : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pc    = pc_q;
  assign bus   = bus_q;
  assign done  = done_q;
  assign dbg_q = r_q[dbg_sel];

  // OP_ADD is the default arithmetic path; keep the name referenced for readers
  logic unused_op_add;
  assign unused_op_add = ^OP_ADD;

endmodule

// File: tb/tb_param_multicycle_proc.sv
// Scoreboard bench for param_multicycle_proc: ROM program, done spacing, pc wrap,
// run drop mid-add and reset during ALU.
module tb_param_multicycle_proc;

  logic       M_clock = 1'b0;
  logic       resetn;
  logic       run;
  logic [7:0] DIN;
  logic [4:0] pc;
  logic [7:0] bus;
  logic       done;
  logic [2:0] dbg_sel;
  logic [7:0] dbg_q;

  param_multicycle_proc #(.DATA_W(8), .NREG(8), .ADDR_W(5)) dut (
    .M_clock (M_clock),
    .resetn  (resetn),
    .run     (run),
    .DIN     (DIN),
    .pc      (pc),
    .bus     (bus),
    .done    (done),
    .dbg_sel (dbg_sel),
    .dbg_q   (dbg_q)
  );

  always #5 M_clock = ~M_clock;

  // Synchronous ROM: data valid one cycle after pc
  logic [7:0] rom [32];
  always_ff @(posedge M_clock) DIN <= rom[pc];

  typedef struct {
    logic [7:0] bus_v;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] b, input int g);
    exp_t e;
    e.bus_v = b;
    e.gap   = g;
    sb.push_back(e);
  endtask

  task automatic check_reg(input int idx, input logic [7:0] exp);
    dbg_sel = 3'(idx);
    #1;
    check($sformatf("R%0d", idx), 32'(dbg_q), 32'(exp));
  endtask

  // Returns at the negedge where the n-th done pulse is seen
  task automatic wait_dones(input int n, input string tag);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 300) begin
      @(negedge M_clock);
      cyc++;
      if (done) seen++;
    end
    if (seen < n) begin
      errors++;
      checks++;
      $display("FAIL %s: timeout, got %0d done pulses expected %0d", tag, seen, n);
    end
  endtask

  // Monitor: pops an expectation per done pulse, checks spacing, width and bus
  initial begin : monitor
    int         cyc      = 0;
    int         last     = 0;
    bit         pend     = 0;
    logic [7:0] pend_bus = '0;
    exp_t       e;
    forever begin
      @(negedge M_clock);
      cyc++;
      if (pend) begin
        check("done_width", 32'(done), 32'd0);
        check("bus_after_write", 32'(bus), 32'(pend_bus));
        pend = 0;
      end else if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          if (e.gap != 0) check("done_spacing", 32'(cyc - last), 32'(e.gap));
          pend     = 1;
          pend_bus = e.bus_v;
        end
        last = cyc;
      end
    end
  end

  initial begin : stim
    // Program: mvi/add/sub/mv chain, X==Y cases, then mv filler up to an mvi at 31
    rom[0]  = 8'h01; rom[1]  = 8'h05;   // mvi R0,0x05
    rom[2]  = 8'h05; rom[3]  = 8'h03;   // mvi R1,0x03
    rom[4]  = 8'h22;                    // add R0,R1
    rom[5]  = 8'h09; rom[6]  = 8'h02;   // mvi R2,0x02
    rom[7]  = 8'h0D; rom[8]  = 8'h05;   // mvi R3,0x05
    rom[9]  = 8'h6B;                    // sub R2,R3
    rom[10] = 8'h50;                    // mv R4,R2
    rom[11] = 8'h26;                    // add R1,R1
    rom[12] = 8'h6F;                    // sub R3,R3
    rom[13] = 8'hB4;                    // mv R5,R5
    for (int i = 14; i <= 30; i++) rom[i] = 8'h18;  // mv R6,R0
    rom[31] = 8'h1D;                    // mvi R7, immediate from address 0

    resetn  = 1'b0;
    run     = 1'b1;
    dbg_sel = '0;
    repeat (2) @(negedge M_clock);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bus", 32'(bus), 32'd0);
    for (int i = 0; i < 8; i++) check_reg(i, 8'h00);

    // Phase A: full program
    push(8'h05, 0); push(8'h03, 4); push(8'h08, 5);
    push(8'h02, 4); push(8'h05, 4); push(8'hFD, 5);
    push(8'hFD, 3); push(8'h06, 5); push(8'h00, 5); push(8'h00, 3);
    for (int i = 0; i < 17; i++) push(8'h08, 3);
    push(8'h01, 4);
    @(negedge M_clock);
    resetn = 1'b1;
    wait_dones(27, "phaseA_mv");
    @(negedge M_clock);
    run = 1'b0;
    wait_dones(1, "phaseA_wrap_mvi");
    repeat (3) @(negedge M_clock);
    check("wrap_pc", 32'(pc), 32'd1);
    repeat (3) @(negedge M_clock);
    check("idle_pc_frozen", 32'(pc), 32'd1);
    check_reg(0, 8'h08); check_reg(1, 8'h06); check_reg(2, 8'hFD); check_reg(3, 8'h00);
    check_reg(4, 8'hFD); check_reg(5, 8'h00); check_reg(6, 8'h08); check_reg(7, 8'h01);

    // Phase B: drop run during add
    resetn = 1'b0;
    repeat (2) @(negedge M_clock);
    check("rstB_pc", 32'(pc), 32'd0);
    check_reg(2, 8'h00);
    push(8'h05, 0); push(8'h03, 4); push(8'h08, 5);
    resetn = 1'b1;
    run    = 1'b1;
    wait_dones(2, "phaseB_mvi");
    @(negedge M_clock);
    run = 1'b0;
    wait_dones(1, "phaseB_add");
    repeat (2) @(negedge M_clock);
    check("runoff_pc", 32'(pc), 32'd5);
    repeat (4) @(negedge M_clock);
    check("runoff_pc_frozen", 32'(pc), 32'd5);
    check_reg(0, 8'h08);
    check_reg(1, 8'h03);

    // Phase C: reset while sub R2,R3 is in ALU
    @(negedge M_clock);
    push(8'h02, 0); push(8'h05, 4);
    run = 1'b1;
    wait_dones(2, "phaseC_mvi");
    repeat (4) @(negedge M_clock);
    resetn = 1'b0;
    run    = 1'b0;
    @(negedge M_clock);
    resetn = 1'b1;
    repeat (8) @(negedge M_clock);
    check("rstALU_done", 32'(done), 32'd0);
    check("rstALU_pc", 32'(pc), 32'd0);
    check("rstALU_bus", 32'(bus), 32'd0);
    check_reg(2, 8'h00);
    check_reg(3, 8'h00);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
